mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: byte-serial RAM port shared by instruction fetch and LSB.
// Define RVC_FETCH_EN to end a fetch after 2 bytes on a 16-bit opcode.
module mem_arbiter (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        inst_ready,
  output logic [31:0] inst_val,
  output logic        is_c,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_width,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    STORE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_k;
  logic [1:0]  r_last;
  logic [1:0]  r_drain;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [31:0] r_inst;
  logic [31:0] r_rdata;
  logic        r_lsb_last;
`ifdef RVC_FETCH_EN
  logic        r_cflag;
`endif

  logic        w_if_ok;
  logic        w_lsb_ok;
  logic        w_pick_lsb;
  logic        w_grant;
  logic        w_rd;
  logic        w_issue;
  logic        w_fin;
  logic        w_back;
  logic        w_cap;
  logic [1:0]  w_cap_idx;
  logic        w_if_done;
  logic        w_ld_done;
  logic        w_st_done;
`ifdef RVC_FETCH_EN
  logic        w_rvc_short;
`endif

  // clear blocks new fetches and loads but lets a store through
  assign w_if_ok    = if_enable & ~clear;
  assign w_lsb_ok   = lsb_req & (lsb_wr | ~clear);
  assign w_pick_lsb = w_lsb_ok & (~w_if_ok | ~r_lsb_last);
  assign w_grant    = w_if_ok | w_lsb_ok;

  // r_drain: 0 = issuing addresses, 1 = last read byte, 2 = done cycle
  assign w_rd    = (r_state == FETCH) | (r_state == LOAD);
  assign w_issue = (r_state != IDLE) & (r_drain == 2'd0);
  assign w_fin   = (r_state != IDLE) & (r_drain == 2'd2);

  // while paused, re-present the address whose byte is still owed
  assign w_back    = w_rd & w_issue & ~rdy_in & (r_k != 2'd0);
  assign w_cap     = w_rd & rdy_in &
                     ((w_issue & (r_k != 2'd0)) | (r_drain == 2'd1));
  assign w_cap_idx = (r_drain == 2'd1) ? r_k : r_k - 2'd1;

`ifdef RVC_FETCH_EN
  assign w_rvc_short = (r_state == FETCH) & w_issue &
                       (r_k == 2'd2) & (r_buf[1:0] != 2'b11);
`endif

  assign w_if_done = (r_state == FETCH) & w_fin & rdy_in & ~clear;
  assign w_ld_done = (r_state == LOAD) & w_fin & rdy_in & ~clear;
  assign w_st_done = (r_state == STORE) & w_fin & rdy_in;

  assign mem_a    = (r_state == IDLE) ? 32'd0 :
                    r_addr + {30'd0, r_k} - {31'd0, w_back};
  assign mem_wr   = (r_state == STORE) & w_issue & rdy_in;
  assign mem_dout = ((r_state == STORE) & w_issue) ?
                    r_wdata[{r_k, 3'b000} +: 8] : 8'd0;

  assign inst_ready = w_if_done;
  assign inst_val   = w_if_done ? r_buf : r_inst;
`ifdef RVC_FETCH_EN
  assign is_c       = w_if_done & r_cflag;
`else
  assign is_c       = 1'b0;
`endif
  assign lsb_done   = w_ld_done | w_st_done;
  assign lsb_rdata  = w_ld_done ? r_buf : r_rdata;

  // arbitration, byte sequencing and read-data assembly
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= IDLE;
      r_k        <= 2'd0;
      r_last     <= 2'd0;
      r_drain    <= 2'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_buf      <= 32'd0;
      r_inst     <= 32'd0;
      r_rdata    <= 32'd0;
      r_lsb_last <= 1'b1;
`ifdef RVC_FETCH_EN
      r_cflag    <= 1'b0;
`endif
    end else if (rdy_in) begin
      if (w_cap) r_buf[{w_cap_idx, 3'b000} +: 8] <= mem_din;
      if (w_if_done) r_inst <= r_buf;
      if (w_ld_done) r_rdata <= r_buf;
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_k        <= 2'd0;
            r_drain    <= 2'd0;
            r_buf      <= 32'd0;
            r_lsb_last <= w_pick_lsb;
`ifdef RVC_FETCH_EN
            r_cflag    <= 1'b0;
`endif
            if (w_pick_lsb) begin
              r_addr  <= lsb_addr;
              r_wdata <= lsb_wdata;
              r_last  <= (lsb_width == 2'b00) ? 2'd0 :
                         (lsb_width == 2'b01) ? 2'd1 : 2'd3;
              r_state <= lsb_wr ? STORE : LOAD;
            end else begin
              r_addr  <= if_addr;
              r_last  <= 2'd3;
              r_state <= FETCH;
            end
          end
        end
        FETCH, LOAD: begin
          if (clear) begin
            r_state <= IDLE;
            r_drain <= 2'd0;
            r_k     <= 2'd0;
`ifdef RVC_FETCH_EN
          end else if (w_rvc_short) begin
            r_drain <= 2'd2;
            r_cflag <= 1'b1;
`endif
          end else if (w_issue) begin
            if (r_k == r_last) r_drain <= 2'd1;
            else r_k <= r_k + 2'd1;
          end else if (r_drain == 2'd1) begin
            r_drain <= 2'd2;
          end else begin
            r_state <= IDLE;
            r_drain <= 2'd0;
            r_k     <= 2'd0;
          end
        end
        STORE: begin
          if (w_issue) begin
            if (r_k == r_last) r_drain <= 2'd2;
            else r_k <= r_k + 2'd1;
          end else begin
            r_state <= IDLE;
            r_drain <= 2'd0;
            r_k     <= 2'd0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
